// File: rtl/key_sw_debounce_if.sv
// rtl/key_sw_debounce_if.sv - raw board inputs and conditioned outputs of the key/switch debouncer
interface key_sw_debounce_if;
    logic [3:0] key;
    logic [3:0] sw;
    logic [3:0] key_db;
    logic [3:0] sw_db;
    logic [3:0] key_press;
    logic [3:0] key_release;

    modport master (
        output key,
        output sw,
        input  key_db,
        input  sw_db,
        input  key_press,
        input  key_release
    );

    modport slave (
        input  key,
        input  sw,
        output key_db,
        output sw_db,
        output key_press,
        output key_release
    );
endinterface

// File: rtl/key_sw_debounce.sv
// rtl/key_sw_debounce.sv - two-flop synchroniser, per-bit debounce counter and key press/release pulses
module key_sw_debounce #(
    parameter int unsigned DB_CYCLES      = 240000,
    parameter bit          KEY_ACTIVE_LOW = 1'b1,
    parameter int unsigned CNT_W          = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    key_sw_debounce_if.slave dbi
);
    localparam logic [3:0]       REL     = KEY_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [7:0]       RST_LVL = {4'h0, REL};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    // Bits [3:0] are keys, bits [7:4] are switches; all eight are handled identically.
    logic [7:0]       s1;
    logic [7:0]       s2;
    logic [7:0]       stable;
    logic [7:0]       stable_nxt;
    logic [7:0]       upd;
    logic [CNT_W-1:0] cnt     [8];
    logic [CNT_W-1:0] cnt_nxt [8];
    logic [3:0]       press_q;
    logic [3:0]       release_q;

    always_comb begin
        stable_nxt = stable;
        upd        = '0;
        for (int i = 0; i < 8; i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != stable[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    stable_nxt[i] = s2[i];
                    upd[i]        = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1        <= RST_LVL;
            s2        <= RST_LVL;
            stable    <= RST_LVL;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1     <= {dbi.sw, dbi.key};
            s2     <= s1;
            stable <= stable_nxt;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            // Pulses are registered alongside the level, so they line up with the key_db edge.
            press_q   <= upd[3:0] & (stable_nxt[3:0] ^ REL);
            release_q <= upd[3:0] & ~(stable_nxt[3:0] ^ REL);
        end
    end

    assign dbi.key_db      = stable[3:0];
    assign dbi.sw_db       = stable[7:4];
    assign dbi.key_press   = press_q;
    assign dbi.key_release = release_q;
endmodule

// File: tb/tb_key_sw_debounce.sv
// tb/tb_key_sw_debounce.sv - bench for key_sw_debounce: windowed reference model plus directed latency checks
module tb_key_sw_debounce;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    key_sw_debounce_if ifa ();
    key_sw_debounce_if ifb ();

    key_sw_debounce #(.DB_CYCLES(8), .KEY_ACTIVE_LOW(1'b1), .CNT_W(24)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .dbi   (ifa)
    );

    key_sw_debounce #(.DB_CYCLES(1), .KEY_ACTIVE_LOW(1'b0), .CNT_W(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .dbi   (ifb)
    );

    int checks = 0;
    int errors = 0;
    int pc2    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a level is adopted once the last DB synchronised samples, all taken outside reset,
    // disagree with the current level. Samples reach the decision two edges after capture.
    int unsigned dbc  [2] = '{8, 1};
    logic [3:0]  relv [2] = '{4'hF, 4'h0};
    logic [7:0]  st_m [2];
    logic [7:0]  hd1  [2];
    logic [7:0]  hd2  [2];
    logic [3:0]  pr_m [2];
    logic [3:0]  rl_m [2];
    logic [8:0]  win  [2][8];
    logic        cap_rst;
    logic        cap_ok = 1'b0;
    logic [7:0]  cap_raw [2];

    task automatic model_step(input int m);
        logic [7:0] rstv = {4'h0, relv[m]};
        logic [7:0] s2e;
        logic [7:0] flip;
        logic [7:0] nst;
        if (!cap_rst) begin
            st_m[m] = rstv;
            pr_m[m] = 4'h0;
            rl_m[m] = 4'h0;
            hd1[m]  = rstv;
            hd2[m]  = rstv;
            for (int i = 0; i < 8; i++) win[m][i] = 9'h0;
        end else begin
            s2e    = hd2[m];
            hd2[m] = hd1[m];
            hd1[m] = cap_raw[m];
            for (int i = 7; i > 0; i--) win[m][i] = win[m][i-1];
            win[m][0] = {1'b1, s2e};
            flip = 8'hFF;
            for (int j = 0; j < int'(dbc[m]); j++)
                flip &= {8{win[m][j][8]}} & (win[m][j][7:0] ^ st_m[m]);
            nst     = st_m[m] ^ flip;
            pr_m[m] = flip[3:0] & (nst[3:0] ^ relv[m]);
            rl_m[m] = flip[3:0] & ~(nst[3:0] ^ relv[m]);
            st_m[m] = nst;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cap_rst    = rst_n;
        cap_raw[0] = {ifa.sw, ifa.key};
        cap_raw[1] = {ifb.sw, ifb.key};
        cap_ok     = 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (cap_ok) begin
            model_step(0);
            model_step(1);
            chk("a_key_db",      ifa.key_db,      st_m[0][3:0]);
            chk("a_sw_db",       ifa.sw_db,       st_m[0][7:4]);
            chk("a_key_press",   ifa.key_press,   pr_m[0]);
            chk("a_key_release", ifa.key_release, rl_m[0]);
            chk("b_key_db",      ifb.key_db,      st_m[1][3:0]);
            chk("b_sw_db",       ifb.sw_db,       st_m[1][7:4]);
            chk("b_key_press",   ifb.key_press,   pr_m[1]);
            chk("b_key_release", ifb.key_release, rl_m[1]);
            if (ifa.key_press[2]) pc2++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold(input logic [3:0] k, input int n);
        @(negedge clk);
        ifa.key = k;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic wait_press(input int inst, input int exp_n, input string name);
        int n;
        logic [3:0] p;
        n = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            n++;
            p = (inst == 0) ? ifa.key_press : ifb.key_press;
            if (p != 4'h0) break;
        end
        chk(name, n, exp_n);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.key = 4'h0;
        ifa.sw  = 4'hF;
        ifb.key = 4'h0;
        ifb.sw  = 4'h0;

        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_key_db", ifa.key_db, 4'hF);
            chk("rst_sw_db",  ifa.sw_db,  4'h0);
            chk("rst_pulses", {ifa.key_press, ifa.key_release}, 8'h00);
            chk("rst_b_key_db", ifb.key_db, 4'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_key_db", ifa.key_db, 4'hF);
        chk("post_rst_sw_db",  ifa.sw_db,  4'h0);
        chk("post_rst_pulses", {ifa.key_press, ifa.key_release}, 8'h00);
        @(negedge clk);
        ifa.key = 4'hF;
        ifa.sw  = 4'h0;
        idle(20);

        @(negedge clk);
        ifa.key = 4'hE;
        wait_press(0, 10, "press0_latency");
        chk("press0_val",     ifa.key_press,   4'h1);
        chk("press0_key_db",  ifa.key_db,      4'hE);
        chk("press0_release", ifa.key_release, 4'h0);
        @(posedge clk);
        #1;
        chk("press0_one_cycle", ifa.key_press, 4'h0);
        hold(4'hF, 12);

        pc2 = 0;
        repeat (10) begin
            hold(4'hB, 2);
            hold(4'hF, 2);
        end
        idle(15);
        chk("bounce_hi_pulses", pc2, 0);
        chk("bounce_hi_key_db", ifa.key_db, 4'hF);
        pc2 = 0;
        repeat (10) begin
            hold(4'hB, 2);
            hold(4'hF, 2);
        end
        @(negedge clk);
        ifa.key = 4'hB;
        wait_press(0, 10, "bounce_lo_latency");
        chk("bounce_lo_val", ifa.key_press, 4'h4);
        idle(15);
        chk("bounce_lo_pulses", pc2, 1);

        hold(4'hF, 12);
        hold(4'hD, 12);
        @(negedge clk);
        ifa.key = 4'h7;
        ifa.sw  = 4'hA;
        wait_press(0, 10, "simul_latency");
        chk("simul_press",   ifa.key_press,   4'h8);
        chk("simul_release", ifa.key_release, 4'h2);
        chk("simul_sw_db",   ifa.sw_db,       4'hA);
        hold(4'hF, 12);

        @(negedge clk);
        ifa.key = 4'hE;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("midrst_key_db", ifa.key_db, 4'hF);
            chk("midrst_pulses", {ifa.key_press, ifa.key_release}, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_press(0, 10, "rst_release_latency");
        chk("rst_release_press", ifa.key_press, 4'h1);

        @(negedge clk);
        ifb.key = 4'h5;
        wait_press(1, 3, "b_latency");
        chk("b_key_db_val", ifb.key_db,      4'h5);
        chk("b_press_val",  ifb.key_press,   4'h5);
        chk("b_release",    ifb.key_release, 4'h0);
        @(posedge clk);
        #1;
        chk("b_press_one_cycle", ifb.key_press, 4'h0);

        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_sw_debounce.md
Name: key_sw_debounce

Overview:
- Input-conditioning stage directly upstream of the LED driver.
- Takes the raw, asynchronous, bouncing board inputs `key[3:0]` and `sw[3:0]`, and synchronises and debounces each bit independently.
- Delivers glitch-free levels for the LED stage to drive `led[7:4]` and `led[3:0]`.
- Also emits one-cycle press and release pulses per key for downstream sequential logic.

Parameters:
- DB_CYCLES, 240000, number of consecutive clk cycles a synchronised input must differ from its stable value before the stable value updates (20 ms at 12 MHz); legal range 1 to 2^24-1.
- KEY_ACTIVE_LOW, 1, 1 = a key reads 0 when pressed; 0 = a key reads 1 when pressed.
- CNT_W, 24, width of each debounce counter; must satisfy 2^CNT_W > DB_CYCLES.

Ports:
- clk  input  1  system clock; the only clock in the block.
- rst_n  input  1  synchronous, active-low reset.
- key  input  4  raw push-button inputs, asynchronous to clk.
- sw  input  4  raw slide-switch inputs, asynchronous to clk.
- key_db  output  4  debounced key levels, same polarity as key.
- sw_db  output  4  debounced switch levels, same polarity as sw.
- key_press  output  4  one-cycle pulse per bit when key_db enters the pressed level.
- key_release  output  4  one-cycle pulse per bit when key_db leaves the pressed level.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled only on the rising edge of clk; there is no asynchronous path.
- Reset values:
  - Key side: key sync stages = REL, key_db = REL, where REL = 4'hF if KEY_ACTIVE_LOW else 4'h0.
  - Switch side: sw sync stages = 4'h0, sw_db = 4'h0.
  - All counters = 0; key_press = key_release = 4'h0.
- Synchroniser: each of the 8 bits passes through a 2-flop chain (s1, s2). Only s2 feeds the debounce logic.
- Debounce, per bit, evaluated every clk edge outside reset:
  - If s2 == stable: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: stable <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any bounce back to the stable value before expiry restarts the count from 0.
  - DB_CYCLES = 1 means stable follows s2 one cycle after a mismatch.
- Latency: a raw level first captured by s1 at edge E reaches s2 at E+1 and appears on key_db/sw_db at edge E+DB_CYCLES+1, provided it is held throughout.
- Pulses:
  - key_press[i] is registered and asserted for exactly one cycle, on the same edge key_db[i] changes to the pressed level.
  - key_release[i] behaves the same on a change to the released level.
  - Press and release are never both high for the same bit in the same cycle.
  - Bits are fully independent; simultaneous events on several bits produce simultaneous pulses.
- Counter saturation: cnt never exceeds DB_CYCLES-1, so no wrap-around occurs.
- Reset mid-count: all counters clear and all levels return to reset values on the next edge. No pulse is generated by reset itself.
- After reset release, a key held pressed throughout reset produces key_press after DB_CYCLES+2 cycles.
- Switches have no pulse outputs; sw_db is level-only.
- The block is purely registered on all outputs; no combinational path exists from key/sw to any output.

Test Plan (DB_CYCLES=8, KEY_ACTIVE_LOW=1 unless stated):
1. Reset: hold rst_n=0 for 3 cycles with key=4'h0, sw=4'hF -> key_db=4'hF, sw_db=4'h0, key_press=key_release=4'h0 during reset and on the first edge after release.
2. Clean press: drive key[0] 1->0 and hold -> key_db[0] falls exactly 10 edges after the first sampling edge. key_press=4'h1 for that single cycle; key_release stays 0.
3. Bounce rejection: toggle key[2] with a period of 4 cycles for 40 cycles, then leave it at 1 -> key_db stays 4'hF and no pulses occur. Repeat ending at 0 -> exactly one key_press[2] pulse, 10 edges after the final transition.
4. Simultaneous events: release key[1] and press key[3] on the same edge while sw=4'hA is applied -> key_release=4'h2 and key_press=4'h8 in the same cycle, and sw_db=4'hA on that same edge.
5. Reset mid-debounce: start a press on key[0], assert rst_n=0 after 5 cycles -> counter clears, key_db=4'hF, no pulse. Release rst_n with key[0] still 0 -> key_press[0] appears DB_CYCLES+2 = 10 cycles later.
6. Polarity and minimum setting: with KEY_ACTIVE_LOW=0 and DB_CYCLES=1, reset to key_db=4'h0, then drive key=4'h5 -> key_db=4'h5 three edges later, with key_press=4'h5 for exactly one cycle.
